seg7_bcd_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_bcd_scan.sv | 157 +++++++++++++++
 tb/tb_seg7_bcd_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD scanner.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_scan.sv
// Binary-to-BCD (sequential double-dabble) plus 3-digit multiplexed common-anode display.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero hundreds/tens slots.
module seg7_bcd_scan
    import seg7_pkg::*;
#(
    parameter int N        = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [6:0]   seg,
    output logic [3:0]   an,
    output logic         busy
);

    localparam int PW = $clog2(SCAN_DIV);

    state_t         state_q, state_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [N-1:0]   cap_q, cap_d;
    logic [N-1:0]   last_q, last_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [11:0]    disp_q, disp_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [11:0]    adj_s;

    logic [PW-1:0]  presc_q;
    logic [1:0]     idx_q;
    logic [3:0]     an_q;
    logic [6:0]     seg_q;
    logic [1:0]     idx_nxt_s;
    logic [3:0]     digit_s;
    logic [6:0]     dec_s;
    logic           blank_s;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cap_q   <= '0;
            last_q  <= '0;
            bcd_q   <= 12'd0;
            disp_q  <= 12'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cap_d   = cap_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        adj_s   = 12'd0;
        case (state_q)
            IDLE: begin
                if (din != last_q) begin
                    cap_d   = din;
                    sh_d    = din;
                    bcd_d   = 12'd0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                adj_s          = dabble_adjust(bcd_q);
                {bcd_d, sh_d}  = {adj_s[10:0], sh_q, 1'b0};
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = LATCH;
                end else begin
                    state_d = SHIFT;
                end
            end
            LATCH: begin
                disp_d  = bcd_q;
                last_d  = cap_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Scan slot selection for the slot about to be shown.
    always_comb begin
        idx_nxt_s = 2'd0;
        digit_s   = 4'd0;
        blank_s   = 1'b0;
        if (idx_q == 2'(DIGITS - 1)) begin
            idx_nxt_s = 2'd0;
        end else begin
            idx_nxt_s = idx_q + 2'd1;
        end
        case (idx_nxt_s)
            2'd0:    digit_s = disp_q[3:0];
            2'd1:    digit_s = disp_q[7:4];
            default: digit_s = disp_q[11:8];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_s = ((idx_nxt_s == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                  ((idx_nxt_s == 2'd1) && (disp_q[11:4] == 8'd0));
`else
        blank_s = 1'b0;
`endif
    end

    seg7_decode u_decode (
        .bcd_i (digit_s),
        .seg_o (dec_s)
    );

    // Prescaler, scan index and registered display drive; outputs only move on a slot change.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1110;
            seg_q   <= SEG_0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= idx_nxt_s;
            an_q    <= blank_s ? AN_OFF : (AN_OFF & ~(4'b0001 << idx_nxt_s));
            seg_q   <= blank_s ? SEG_BLANK : dec_s;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Randomized self-checking bench for seg7_bcd_scan with SCAN_DIV=4 against an arithmetic model.
module tb_seg7_bcd_scan;

    localparam int SDIV = 4;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    int shown    = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    seg7_bcd_scan #(.N(8), .SCAN_DIV(SDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since the last reset edge; the scan slot follows directly from it.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {an, seg} for a displayed value in a given scan slot.
    function automatic logic [10:0] exp_scan(input int v, input int slot);
        int         d;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        d     = (slot == 0) ? v % 10 : (slot == 1) ? (v / 10) % 10 : v / 100;
        an_e  = ~(4'b0001 << slot);
        seg_e = seg_tab[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((slot == 2 && v < 100) || (slot == 1 && v < 10)) begin
            an_e  = 4'b1111;
            seg_e = 7'b1111111;
        end
`endif
        return {an_e, seg_e};
    endfunction

    task automatic scan_cycles(input int n, input int v, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, {an, seg}, exp_scan(v, (k / SDIV) % 3));
        end
    endtask

    // Apply a value while idle, check busy duration, then the scanned digits.
    task automatic convert(input int v);
        int nb;
        int exp_nb;
        exp_nb = (v != shown) ? 9 : 0;
        din = 8'(v);
        nb  = 0;
        tick();
        check("busy_start", busy, (exp_nb != 0) ? 1 : 0);
        if (busy) nb++;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (busy) nb++;
        end
        check("busy_len", nb, exp_nb);
        shown = v;
        repeat (3 * SDIV) tick();
        scan_cycles(3 * SDIV, v, "scan");
    endtask

    initial begin
        logic [19:0] bseq;
        logic [19:0] bexp;
        int v;

        reset = 1'b1;
        din   = 8'd0;
        repeat (3) tick();
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_scan", {an, seg}, exp_scan(0, (k / SDIV) % 3));
        end

        convert(255);
        convert(0);
        convert(255);
        convert(255);
        convert(105);
        convert(7);

        // Value changes on the 3rd SHIFT cycle: 128 latches, then 9 is converted right after.
        din = 8'd128;
        for (int i = 0; i < 20; i++) begin
            tick();
            bseq[i] = busy;
            if (i == 2) din = 8'd9;
        end
        bexp = 20'b0;
        for (int i = 0; i < 9; i++) begin
            bexp[i]      = 1'b1;
            bexp[i + 10] = 1'b1;
        end
        check("busy_retrig", bseq, bexp);
        shown = 9;
        repeat (3 * SDIV) tick();
        scan_cycles(3 * SDIV, 9, "scan_retrig");

        // Reset on the 5th SHIFT cycle aborts; 200 is converted afresh after release.
        din = 8'd200;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_an", an, 4'b1110);
        check("abort_seg", seg, 7'b1000000);
        reset = 1'b0;
        shown = 0;
        convert(200);

        for (int i = 0; i < 12; i++) begin
            v = (i % 4 == 3) ? shown : int'($urandom_range(0, 255));
            convert(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
